// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-entry stall buffer
// Drives the I-cache request and presents one IF/ID load pulse per delivered word.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic [31:0] instr_out,
  output logic [31:0] pc_4_out,
  output logic        fetch_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = {redirect_addr[31:2], 2'b00};

  assign imemREN     = (state_q == FETCH);
  assign imemaddr    = pc_q;
  assign instr_out   = instr_q;
  assign pc_4_out    = pc4_q;
  assign fetch_valid = valid_q;
  assign fetch_count = count_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = 1'b0;
    count_d = count_q;
    buf_d   = buf_q;

    if (halt) begin
      state_d = HALTED;
      buf_d   = 32'd0;
    end else begin
      case (state_q)
        FETCH: begin
          if (redirect) begin
            pc_d = redirect_pc;
          end else if (ihit) begin
            pc_d = pc_plus4;
            if (stall) begin
              buf_d   = imemload;
              state_d = HOLD;
            end else begin
              instr_d = imemload;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
              count_d = count_q + 32'd1;
            end
          end
        end
        HOLD: begin
          // PC already advanced past the buffered word, so it is that word's PC+4.
          if (redirect) begin
            pc_d    = redirect_pc;
            buf_d   = 32'd0;
            state_d = FETCH;
          end else if (!stall) begin
            instr_d = buf_q;
            pc4_d   = pc_q;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
            buf_d   = 32'd0;
            state_d = FETCH;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
      buf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
      buf_q   <= buf_d;
    end
  end

endmodule
